// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// lsu -- single-outstanding load/store unit
//
// Accepts one load or store request and computes the effective address as
// base + offset. It issues one lane-aligned memory access, then returns one
// response. Only one transaction is in flight at a time.
//
// Parameters
//   XLEN  data/address width (32 or 64)
//   NB    byte-lane count, derived as XLEN/8 (local, not overridable)
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req_valid / req_ready     request handshake (req_ready only in IDLE)
//   req_store, req_funct3     1=store / 0=load, RISC-V width/sign code
//   req_base, req_offset      address operands, ea = base + offset (mod 2^XLEN)
//   req_wdata                 store data, right-justified
//   resp_valid / resp_ready   response handshake
//   resp_rdata, resp_err      extended load data (0 for stores), error flag
//   mem_req / mem_gnt         memory request handshake
//   mem_we, mem_addr, mem_be  write enable, NB-aligned address, byte enables
//   mem_wdata                 lane-shifted store data
//   mem_rvalid, mem_rdata     lane-aligned read data return
//
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  defined: an access whose ea is not a multiple of its
//                         size returns resp_err without touching memory.
//                         undefined: ea is aligned down to the access size.
// ----------------------------------------------------------------------------
module lsu #(
    parameter int  XLEN = 32,
    localparam int NB   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [XLEN-1:0] req_offset,
    input  logic [XLEN-1:0] req_wdata,

    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,

    output logic            mem_req,
    input  logic            mem_gnt,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [NB-1:0]   mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int LW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t        state;

    // Request attributes kept for the load-data extraction in WAIT.
    logic          store_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [LW-1:0] lane_q;

    // Contiguous byte-enable pattern for an access of 2^sz bytes at lane 0.
    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i < (1 << sz));
        end
        return m;
    endfunction

    // Sign- or zero-extend the low 2^sz bytes of v to the full width.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                               input logic [1:0]      sz,
                                               input logic            uns);
        logic [XLEN-1:0] r;
        logic            fill;
        int              nbits;
        nbits = 8 << sz;
        if (nbits > XLEN) begin
            nbits = XLEN;
        end
        case (sz)
            2'd0:    fill = v[7];
            2'd1:    fill = v[15];
            2'd2:    fill = v[31];
            default: fill = v[XLEN-1];
        endcase
        if (uns) begin
            fill = 1'b0;
        end
        r = v;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= nbits) begin
                r[i] = fill;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ea;
    logic [XLEN-1:0] ea_eff;
    logic [XLEN-1:0] sz_bytes;
    logic [1:0]      size;
    logic            illegal;
    logic            err_c;
    logic [LW-1:0]   lane;
    logic [NB-1:0]   be_c;
    logic [XLEN-1:0] wdata_c;
    logic [XLEN-1:0] addr_c;
    logic [XLEN-1:0] load_data;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this
        // block can leave a value unassigned and infer a latch.
        ea       = req_base + req_offset;
        size     = req_funct3[1:0];
        sz_bytes = XLEN'(1) << size;

        illegal = (req_funct3 == 3'd7) || (req_store && req_funct3[2]);
        if (XLEN == 32 && (req_funct3 == 3'd3 || req_funct3 == 3'd6)) begin
            illegal = 1'b1;
        end

`ifdef LSU_MISALIGN_TRAP_EN
        ea_eff = ea;
        err_c  = illegal || ((ea & (sz_bytes - XLEN'(1))) != '0);
`else
        // Silently round down to the natural alignment of the access.
        ea_eff = ea & ~(sz_bytes - XLEN'(1));
        err_c  = illegal;
`endif

        lane    = ea_eff[LW-1:0];
        be_c    = size_mask(size) << lane;
        wdata_c = req_wdata << {lane, 3'b000};
        addr_c  = {ea_eff[XLEN-1:LW], {LW{1'b0}}};

        load_data = extend(mem_rdata >> {lane_q, 3'b000}, size_q, uns_q);
    end

    // Derived from the state register; forced low while rst is high so the
    // block advertises nothing during reset and is ready the cycle after.
    assign req_ready = (state == IDLE) && !rst;

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            lane_q     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q <= req_store;
                        size_q  <= size;
                        uns_q   <= req_funct3[2];
                        lane_q  <= lane;
                        if (err_c) begin
                            // Errors skip memory entirely.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= addr_c;
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    // mem_* hold their values until the grant arrives.
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        if (store_q) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (mem_rvalid) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// ----------------------------------------------------------------------------
// tb_lsu -- directed self-checking bench for lsu
//
// Instantiates a 32-bit and a 64-bit lsu sharing clock, reset and most
// stimulus; each has its own req_valid so only one is addressed at a time.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid32;
    logic        req_valid64;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_base;
    logic [63:0] req_offset;
    logic [63:0] req_wdata;
    logic        resp_ready;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    logic        r32_req_ready, r32_resp_valid, r32_resp_err;
    logic [31:0] r32_resp_rdata, r32_mem_addr, r32_mem_wdata;
    logic        r32_mem_req, r32_mem_we;
    logic [3:0]  r32_mem_be;

    logic        r64_req_ready, r64_resp_valid, r64_resp_err;
    logic [63:0] r64_resp_rdata, r64_mem_addr, r64_mem_wdata;
    logic        r64_mem_req, r64_mem_we;
    logic [7:0]  r64_mem_be;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] ill_f3 [4] = '{3'd7, 3'd4, 3'd3, 3'd6};
    logic       ill_st [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    lsu #(.XLEN(32)) dut32 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid32),
        .req_ready  (r32_req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_base   (req_base[31:0]),
        .req_offset (req_offset[31:0]),
        .req_wdata  (req_wdata[31:0]),
        .resp_valid (r32_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (r32_resp_rdata),
        .resp_err   (r32_resp_err),
        .mem_req    (r32_mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (r32_mem_we),
        .mem_addr   (r32_mem_addr),
        .mem_be     (r32_mem_be),
        .mem_wdata  (r32_mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata[31:0])
    );

    lsu #(.XLEN(64)) dut64 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid64),
        .req_ready  (r64_req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_base   (req_base),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .resp_valid (r64_resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (r64_resp_rdata),
        .resp_err   (r64_resp_err),
        .mem_req    (r64_mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (r64_mem_we),
        .mem_addr   (r64_mem_addr),
        .mem_be     (r64_mem_be),
        .mem_wdata  (r64_mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid32 = 1'b0;
        req_valid64 = 1'b0;
        req_store   = 1'b0;
        req_funct3  = 3'd0;
        req_base    = '0;
        req_offset  = '0;
        req_wdata   = '0;
        resp_ready  = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;

        // ---------------- reset ----------------
        step();
        step();
        sample();
        chk("rst_req_ready32", 64'(r32_req_ready), 64'd0);
        chk("rst_req_ready64", 64'(r64_req_ready), 64'd0);
        chk("rst_resp_valid",  64'(r32_resp_valid), 64'd0);
        chk("rst_mem_req",     64'(r32_mem_req), 64'd0);
        chk("rst_rdata",       64'(r32_resp_rdata), 64'd0);

        step();
        rst = 1'b0;
        sample();
        chk("post_rst_ready32", 64'(r32_req_ready), 64'd1);
        chk("post_rst_ready64", 64'(r64_req_ready), 64'd1);

        // ---------------- LB, ea=0x103, lane 3 ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b0; req_funct3 = 3'd0;
        req_base = 64'h100; req_offset = 64'd3;
        sample();
        step();
        req_valid32 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("lb_mem_req",  64'(r32_mem_req), 64'd1);
        chk("lb_mem_addr", 64'(r32_mem_addr), 64'h100);
        chk("lb_mem_be",   64'(r32_mem_be), 64'b1000);
        chk("lb_mem_we",   64'(r32_mem_we), 64'd0);
        chk("lb_ready_busy", 64'(r32_req_ready), 64'd0);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h80FF_0000;
        sample();
        chk("lb_wait_no_resp", 64'(r32_resp_valid), 64'd0);
        step();
        mem_rvalid = 1'b0; resp_ready = 1'b1;
        sample();
        chk("lb_resp_valid", 64'(r32_resp_valid), 64'd1);
        chk("lb_resp_rdata", 64'(r32_resp_rdata), 64'hFFFF_FF80);
        chk("lb_resp_err",   64'(r32_resp_err), 64'd0);
        step();
        resp_ready = 1'b0;
        sample();
        chk("lb_done_valid", 64'(r32_resp_valid), 64'd0);
        chk("lb_done_ready", 64'(r32_req_ready), 64'd1);

        // ---------------- SH, ea=0x202 ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b1; req_funct3 = 3'd1;
        req_base = 64'h200; req_offset = 64'd2; req_wdata = 64'h1234_ABCD;
        sample();
        step();
        req_valid32 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("sh_mem_addr",  64'(r32_mem_addr), 64'h200);
        chk("sh_mem_be",    64'(r32_mem_be), 64'b1100);
        chk("sh_mem_wdata", 64'(r32_mem_wdata), 64'hABCD_0000);
        chk("sh_mem_we",    64'(r32_mem_we), 64'd1);
        step();
        mem_gnt = 1'b0; resp_ready = 1'b1;
        sample();
        chk("sh_resp_valid_c2", 64'(r32_resp_valid), 64'd1);
        chk("sh_resp_rdata",    64'(r32_resp_rdata), 64'd0);
        chk("sh_resp_err",      64'(r32_resp_err), 64'd0);
        chk("sh_ready_in_resp", 64'(r32_req_ready), 64'd0);
        step();
        resp_ready = 1'b0;
        sample();
        chk("sh_done_valid", 64'(r32_resp_valid), 64'd0);

        // ---------------- LHU, ea=0x12 ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b0; req_funct3 = 3'd5;
        req_base = 64'h10; req_offset = 64'd2;
        sample();
        step();
        req_valid32 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("lhu_mem_be", 64'(r32_mem_be), 64'b1100);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h9ABC_0000;
        sample();
        step();
        mem_rvalid = 1'b0; resp_ready = 1'b1;
        sample();
        chk("lhu_resp_rdata", 64'(r32_resp_rdata), 64'h0000_9ABC);
        step();
        resp_ready = 1'b0;
        sample();

        // ---------------- illegal funct3 codes on XLEN=32 ----------------
        for (int k = 0; k < 4; k++) begin
            step();
            req_valid32 = 1'b1; req_store = ill_st[k]; req_funct3 = ill_f3[k];
            req_base = 64'h40; req_offset = 64'd0;
            sample();
            step();
            req_valid32 = 1'b0; resp_ready = 1'b1;
            sample();
            chk($sformatf("ill%0d_resp_valid", k), 64'(r32_resp_valid), 64'd1);
            chk($sformatf("ill%0d_resp_err", k),   64'(r32_resp_err), 64'd1);
            chk($sformatf("ill%0d_mem_req", k),    64'(r32_mem_req), 64'd0);
            step();
            resp_ready = 1'b0;
            sample();
            chk($sformatf("ill%0d_done", k), 64'(r32_resp_valid), 64'd0);
        end

        // ---------------- LW, ea=0x3 ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
        req_base = 64'h0; req_offset = 64'd3;
        sample();
        step();
        req_valid32 = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_ready = 1'b1;
        sample();
        chk("mis_mem_req",    64'(r32_mem_req), 64'd0);
        chk("mis_resp_valid", 64'(r32_resp_valid), 64'd1);
        chk("mis_resp_err",   64'(r32_resp_err), 64'd1);
        chk("mis_resp_rdata", 64'(r32_resp_rdata), 64'd0);
        step();
        resp_ready = 1'b0;
        sample();
`else
        mem_gnt = 1'b1;
        sample();
        chk("mis_mem_addr", 64'(r32_mem_addr), 64'h0);
        chk("mis_mem_be",   64'(r32_mem_be), 64'hF);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
        sample();
        step();
        mem_rvalid = 1'b0; resp_ready = 1'b1;
        sample();
        chk("mis_resp_err",   64'(r32_resp_err), 64'd0);
        chk("mis_resp_rdata", 64'(r32_resp_rdata), 64'hDEAD_BEEF);
        step();
        resp_ready = 1'b0;
        sample();
`endif

        // ---------------- SW with grant and response stalls ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_base = 64'h40; req_offset = 64'd0; req_wdata = 64'h55AA_55AA;
        sample();
        for (int i = 0; i < 5; i++) begin
            step();
            req_valid32 = 1'b0;
            sample();
            chk($sformatf("stall%0d_mem_req", i),   64'(r32_mem_req), 64'd1);
            chk($sformatf("stall%0d_mem_addr", i),  64'(r32_mem_addr), 64'h40);
            chk($sformatf("stall%0d_mem_be", i),    64'(r32_mem_be), 64'hF);
            chk($sformatf("stall%0d_mem_wdata", i), 64'(r32_mem_wdata), 64'h55AA_55AA);
            chk($sformatf("stall%0d_mem_we", i),    64'(r32_mem_we), 64'd1);
        end
        step();
        mem_gnt = 1'b1;
        sample();
        chk("stall_gnt_mem_req", 64'(r32_mem_req), 64'd1);
        step();
        mem_gnt = 1'b0;
        sample();
        chk("hold0_resp_valid", 64'(r32_resp_valid), 64'd1);
        for (int i = 1; i < 3; i++) begin
            step();
            sample();
            chk($sformatf("hold%0d_resp_valid", i), 64'(r32_resp_valid), 64'd1);
            chk($sformatf("hold%0d_resp_err", i),   64'(r32_resp_err), 64'd0);
        end
        step();
        resp_ready = 1'b1;
        sample();
        chk("hold_hs_resp_valid", 64'(r32_resp_valid), 64'd1);
        step();
        resp_ready = 1'b0;
        sample();
        chk("hold_after_hs", 64'(r32_resp_valid), 64'd0);
        step();
        sample();
        chk("hold_single_resp", 64'(r32_resp_valid), 64'd0);

        // ---------------- reset while in WAIT ----------------
        step();
        req_valid32 = 1'b1; req_store = 1'b0; req_funct3 = 3'd2;
        req_base = 64'h80; req_offset = 64'd0;
        sample();
        step();
        req_valid32 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("rw_mem_req", 64'(r32_mem_req), 64'd1);
        step();
        mem_gnt = 1'b0; rst = 1'b1;
        sample();
        chk("rw_ready_in_rst", 64'(r32_req_ready), 64'd0);
        step();
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344;
        sample();
        chk("rw_ready_after", 64'(r32_req_ready), 64'd1);
        chk("rw_no_mem_req",  64'(r32_mem_req), 64'd0);
        chk("rw_no_resp0",    64'(r32_resp_valid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        sample();
        chk("rw_no_resp1", 64'(r32_resp_valid), 64'd0);
        chk("rw_idle",     64'(r32_req_ready), 64'd1);

        // ---------------- XLEN=64 LWU, ea=0x1004 ----------------
        step();
        req_valid64 = 1'b1; req_store = 1'b0; req_funct3 = 3'd6;
        req_base = 64'h1000; req_offset = 64'd4;
        sample();
        step();
        req_valid64 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("lwu_mem_req",  64'(r64_mem_req), 64'd1);
        chk("lwu_mem_addr", r64_mem_addr, 64'h1000);
        chk("lwu_mem_be",   64'(r64_mem_be), 64'hF0);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h8765_4321_0000_0000;
        sample();
        step();
        mem_rvalid = 1'b0; resp_ready = 1'b1;
        sample();
        chk("lwu_resp_valid", 64'(r64_resp_valid), 64'd1);
        chk("lwu_resp_rdata", r64_resp_rdata, 64'h0000_0000_8765_4321);
        chk("lwu_resp_err",   64'(r64_resp_err), 64'd0);
        chk("idle32_ignores_rvalid", 64'(r32_resp_valid), 64'd0);
        step();
        resp_ready = 1'b0;
        sample();
        chk("lwu_done", 64'(r64_resp_valid), 64'd0);

        // ---------------- XLEN=64 LD, ea=0x2000 ----------------
        step();
        req_valid64 = 1'b1; req_store = 1'b0; req_funct3 = 3'd3;
        req_base = 64'h2000; req_offset = 64'd0;
        sample();
        step();
        req_valid64 = 1'b0; mem_gnt = 1'b1;
        sample();
        chk("ld_mem_be", 64'(r64_mem_be), 64'hFF);
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hFEDC_BA98_7654_3210;
        sample();
        step();
        mem_rvalid = 1'b0; resp_ready = 1'b1;
        sample();
        chk("ld_resp_rdata", r64_resp_rdata, 64'hFEDC_BA98_7654_3210);
        step();
        resp_ready = 1'b0;
        sample();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width; the legal values are 32 and 64.
REQ-002 Parameter NB, default XLEN/8, SHALL set the byte-lane count; it is derived and SHALL NOT be overridden.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  request present; req_ready  out  1  block accepts request.
REQ-007 req_store  in  1  1=store, 0=load; req_funct3  in  3  RISC-V width/sign code.
REQ-008 req_base, req_offset, req_wdata  in  XLEN  base address, offset, store data.
REQ-009 resp_valid  out  1; resp_ready  in  1; resp_rdata  out  XLEN; resp_err  out  1  misaligned/illegal access.
REQ-010 mem_req  out  1; mem_gnt  in  1; mem_we  out  1; mem_addr  out  XLEN  NB-aligned; mem_be  out  NB; mem_wdata  out  XLEN.
REQ-011 mem_rvalid  in  1; mem_rdata  in  XLEN  lane-aligned read data.

Function
REQ-012 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP; req_ready=1 only in IDLE.
REQ-013 IDLE: on req_valid&req_ready the block SHALL register the request, compute ea=req_base+req_offset modulo 2^XLEN and go to ISSUE, or to RESP with resp_err=1 on error.
REQ-014 Size codes SHALL be: funct3 0/4=byte, 1/5=half, 2/6=word, 3=double; codes 4-6 zero-extend and 0-3 sign-extend loads.
REQ-015 funct3 3 and 6 SHALL be illegal when XLEN=32; funct3 7, and store funct3 4-7, SHALL always be illegal; an illegal code sets resp_err with no memory access.
REQ-016 ISSUE: mem_req=1 and mem_addr=ea with the low log2(NB) bits cleared.
REQ-017 ISSUE: mem_be = size mask << ea[log2(NB)-1:0].
REQ-018 ISSUE: mem_wdata = req_wdata shifted left by 8*lane offset.
REQ-019 All mem_* outputs SHALL stay stable until mem_gnt.
REQ-020 On mem_gnt a store SHALL go to RESP; a load SHALL go to WAIT.
REQ-021 WAIT: on mem_rvalid the block SHALL extract the lane (mem_rdata >> 8*offset), sign/zero-extend it to XLEN, register it into resp_rdata and go to RESP.
REQ-022 RESP: resp_valid=1, with resp_rdata and resp_err held, until resp_ready; then the block SHALL return to IDLE; a store returns resp_rdata=0.
REQ-023 Minimum latency from acceptance (cycle 0) with gnt in cycle 1: store resp_valid in cycle 2; load with rvalid in cycle 2 gives resp_valid in cycle 3.
REQ-024 mem_rvalid outside WAIT SHALL be ignored.
REQ-025 A new request SHALL NOT be accepted in the same cycle as a response handshake; the next acceptance is in IDLE one cycle later.

Reset
REQ-026 On rst the block SHALL go to IDLE and clear every output to 0 (req_ready=0 during rst, 1 in the first cycle after).
REQ-027 Reset mid-transaction SHALL drop the transaction without a response, and a late mem_rvalid SHALL be ignored.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: ea not a multiple of the access size SHALL give resp_err=1 and resp_rdata=0 in RESP the cycle after acceptance, with mem_req never asserted.
REQ-029 Macro LSU_MISALIGN_TRAP_EN undefined: ea SHALL be aligned down to the access size before lane computation, and resp_err SHALL reflect only illegal funct3.

Verification
REQ-030 XLEN=32 LB, base=0x100, offset=3, mem_rdata=0x80FF_0000 in lane 3 -> mem_be=4'b1000, resp_rdata=0xFFFF_FF80, err=0.
REQ-031 XLEN=32 SH, ea=0x202, wdata=0x1234_ABCD -> mem_addr=0x200, mem_be=4'b1100, mem_wdata[31:16]=0xABCD, resp_valid in cycle 2 with gnt in cycle 1.
REQ-032 XLEN=64 LWU, ea=0x1004, mem_rdata=0x8765_4321_0000_0000 -> mem_be=8'hF0, resp_rdata=0x0000_0000_8765_4321.
REQ-033 LW ea=0x3 -> with LSU_MISALIGN_TRAP_EN: no mem_req and err=1; without: mem_addr=0x0, be=4'hF, err=0.
REQ-034 mem_gnt held low 5 cycles, then resp_ready low 3 cycles -> mem_* stable throughout, resp held, a single response.
REQ-035 rst asserted in WAIT, then mem_rvalid -> no resp_valid, state IDLE, req_ready=1 the cycle after rst drops.
